// File: rtl/fetch_stage_pkg.sv
// Shared types, widths, reset constants and small helpers for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN  = 16;
    localparam int unsigned OPC_W = 5;

    localparam logic [XLEN-1:0]  RESET_PC_DEF    = 16'h0000;
    localparam logic [XLEN-1:0]  NOP_INSTR_DEF   = 16'h0800;
    localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 5'b00000;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_PEND  = 2'd3
    } pc_sel_e;

    function automatic logic [XLEN-1:0] pc_plus2(input logic [XLEN-1:0] pc);
        return XLEN'(pc + XLEN'(2));
    endfunction

    function automatic logic is_halt(input logic [XLEN-1:0] instr, input logic [OPC_W-1:0] opc);
        return instr[XLEN-1 -: OPC_W] == opc;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read handshake between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic            imem_rd;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_done;

    modport master (output imem_addr, output imem_rd, input imem_rdata, input imem_done);
    modport slave  (input imem_addr, input imem_rd, output imem_rdata, output imem_done);

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC select {hold, pc+2, redirect, pending redirect}.
module fetch_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         pc_sel,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] pend_pc,
    output logic [XLEN-1:0] pc_q
);

    logic [XLEN-1:0] pc_d;

    // Next-PC mux.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_INC:   pc_d = pc_plus2(pc_q);
            PC_REDIR: pc_d = redirect_pc;
            PC_PEND:  pc_d = pend_pc;
            default:  pc_d = pc_q;
        endcase
    end

    // PC flops, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, buffers a word across decode
// stalls, applies redirects and stops after HALT. Optional macro FETCH_ALIGN_CHK_EN enables the
// misaligned-redirect error path.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0]  RESET_PC    = RESET_PC_DEF,
    parameter logic [XLEN-1:0]  NOP_INSTR   = NOP_INSTR_DEF,
    parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_fetch,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    fetch_stage_if.master        imem,
    output logic [XLEN-1:0]      instruction,
    output logic [XLEN-1:0]      incremented_pc,
    output logic                 flush_fetch,
    output logic                 fetch_halted,
    output logic                 fetch_err
);

    fetch_state_e    state_q, state_d;
    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_halt_q, pend_halt_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic [XLEN-1:0] redir_tgt;
    logic            redir_bad;
    logic            rd_c;
    logic            deliver_c;
    logic [XLEN-1:0] deliver_word;

    // Redirect targets are always halfword aligned; bit 0 is only inspected by the error check.
    assign redir_tgt = {redirect_pc[XLEN-1:1], 1'b0};

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q, err_d;

    assign redir_bad = redirect_pc[0];

    // Sticky misaligned-redirect flag.
    always_comb err_d = err_q | (redirect_valid & redir_bad);

    // Error flop, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign fetch_err = err_q;
`else
    logic unused_redir_lsb;

    assign redir_bad        = 1'b0;
    assign unused_redir_lsb = redirect_pc[0];
    assign fetch_err        = 1'b0;
`endif

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .redirect_pc (redir_tgt),
        .pend_pc     (pend_pc_d),
        .pc_q        (pc_q)
    );

    // Next-state, PC select and delivery decode; priority redirect > done > stall.
    always_comb begin
        state_d      = state_q;
        pc_sel       = PC_HOLD;
        pend_pc_d    = pend_pc_q;
        pend_halt_d  = pend_halt_q;
        hold_d       = hold_q;
        rd_c         = 1'b0;
        deliver_c    = 1'b0;
        deliver_word = NOP_INSTR;

        case (state_q)
            ST_REQ: begin
                rd_c = 1'b1;
                if (redirect_valid) begin
                    if (!imem.imem_done) begin
                        // Request cannot be aborted: remember where to go once it completes.
                        pend_pc_d   = redir_tgt;
                        pend_halt_d = redir_bad;
                        state_d     = ST_DRAIN;
                    end else if (redir_bad) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_sel = PC_REDIR;
                    end
                end else if (imem.imem_done) begin
                    if (!stall_fetch) begin
                        deliver_c    = 1'b1;
                        deliver_word = imem.imem_rdata;
                        pc_sel       = PC_INC;
                        if (is_halt(imem.imem_rdata, HALT_OPCODE)) state_d = ST_HALTED;
                    end else begin
                        hold_d  = imem.imem_rdata;
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_DRAIN: begin
                rd_c = 1'b1;
                if (redirect_valid) begin
                    pend_pc_d   = redir_tgt;
                    pend_halt_d = redir_bad;
                end
                if (imem.imem_done) begin
                    if (pend_halt_d) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_sel  = PC_PEND;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    if (redir_bad) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_sel  = PC_REDIR;
                        state_d = ST_REQ;
                    end
                end else if (!stall_fetch) begin
                    deliver_c    = 1'b1;
                    deliver_word = hold_q;
                    pc_sel       = PC_INC;
                    state_d      = is_halt(hold_q, HALT_OPCODE) ? ST_HALTED : ST_REQ;
                end
            end

            ST_HALTED: begin
                if (redirect_valid && !redir_bad) begin
                    pc_sel  = PC_REDIR;
                    state_d = ST_REQ;
                end
            end

            default: state_d = ST_REQ;
        endcase
    end

    // FSM state, pending redirect and hold buffer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pend_pc_q   <= RESET_PC;
            pend_halt_q <= 1'b0;
            hold_q      <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pend_pc_q   <= pend_pc_d;
            pend_halt_q <= pend_halt_d;
            hold_q      <= hold_d;
        end
    end

    // Output decode; reset forces an idle bus and a NOP toward IF/ID.
    assign imem.imem_addr = pc_q;
    assign imem.imem_rd   = rd_c & ~rst;
    assign flush_fetch    = rst | ~deliver_c;
    assign instruction    = flush_fetch ? NOP_INSTR : deliver_word;
    assign incremented_pc = pc_plus2(pc_q);
    assign fetch_halted   = ~rst & (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: random imem latency, stalls and redirects against a
// program-order model of the delivered instruction stream.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] instruction;
    logic [15:0] incremented_pc;
    logic        flush_fetch;
    logic        fetch_halted;
    logic        fetch_err;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_fetch    (stall_fetch),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .instruction    (instruction),
        .incremented_pc (incremented_pc),
        .flush_fetch    (flush_fetch),
        .fetch_halted   (fetch_halted),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:32767];
    exp_t        expq [$];
    int          tests = 0;
    int          fails = 0;
    int          deliveries = 0;
    bit          model_halted = 1'b0;
    bit          err_halt_ok = 1'b0;
    int          lat_fixed = 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit halt_word(input logic [15:0] w);
        return w[15:11] == 5'b00000;
    endfunction

    // Expected program order from pc: consecutive halfwords up to and including a HALT.
    function automatic void refill(input logic [15:0] start);
        logic [15:0] pc;
        logic [15:0] w;
        pc = start;
        while (expq.size() < 16) begin
            w = mem[pc[15:1]];
            expq.push_back({pc, w});
            if (halt_word(w)) break;
            pc = pc + 16'd2;
        end
    endfunction

    function automatic void model_redirect(input logic [15:0] t);
        expq.delete();
        model_halted = 1'b0;
        refill(t & 16'hFFFE);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory responder with random or fixed latency.
    initial begin : responder
        bit          busy;
        int          wait_cnt;
        logic [15:0] req_addr;
        busy = 1'b0;
        wait_cnt = 0;
        req_addr = 16'h0;
        bus.imem_done  = 1'b0;
        bus.imem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #2;
            bus.imem_done  = 1'b0;
            bus.imem_rdata = 16'($urandom);
            if (rst) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    check("imem_rd_held", 32'(bus.imem_rd), 32'd1);
                    check("imem_addr_stable", 32'(bus.imem_addr), 32'(req_addr));
                end
                if (bus.imem_rd) begin
                    if (!busy) begin
                        busy     = 1'b1;
                        req_addr = bus.imem_addr;
                        wait_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
                    end
                    if (wait_cnt == 0) begin
                        bus.imem_done  = 1'b1;
                        bus.imem_rdata = mem[req_addr[15:1]];
                        busy = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end else begin
                    busy = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every delivery and checks per-cycle invariants.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_imem_rd", 32'(bus.imem_rd), 32'd0);
                check("rst_flush", 32'(flush_fetch), 32'd1);
                check("rst_halted", 32'(fetch_halted), 32'd0);
                continue;
            end
`ifndef FETCH_ALIGN_CHK_EN
            check("fetch_err_tied", 32'(fetch_err), 32'd0);
`endif
            if (stall_fetch) check("stall_flush", 32'(flush_fetch), 32'd1);
            if (redirect_valid) check("redirect_flush", 32'(flush_fetch), 32'd1);
            if (model_halted && !redirect_valid) begin
                check("halted_flag", 32'(fetch_halted), 32'd1);
                check("halted_imem_rd", 32'(bus.imem_rd), 32'd0);
            end
            if (fetch_halted && !model_halted && !redirect_valid && !err_halt_ok)
                check("unexpected_halt", 32'(fetch_halted), 32'd0);
            if (flush_fetch) begin
                check("flush_nop", 32'(instruction), 32'(NOP));
            end else if (expq.size() == 0) begin
                check("unexpected_delivery", 32'(instruction), 32'(NOP));
            end else begin
                e = expq.pop_front();
                deliveries++;
                check("instr", 32'(instruction), 32'(e.instr));
                check("incremented_pc", 32'(incremented_pc), 32'(16'(e.pc + 16'd2)));
                if (halt_word(e.instr)) model_halted = 1'b1;
                else if (expq.size() == 0) refill(16'(e.pc + 16'd2));
            end
        end
    end

    initial begin : stimulus
        logic [15:0] w;
        logic [15:0] t;
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b00000) w[15] = 1'b1;
            if ($urandom_range(0, 31) == 0) w[15:11] = 5'b00000;
            mem[i] = w;
        end
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'hA5A5;
        mem[3] = 16'h0000;
        for (int i = 8; i < 16; i++) mem[i][15] = 1'b1;
        for (int i = 32; i < 40; i++) mem[i][15] = 1'b1;
        mem[32767] = 16'h3333;

        rst = 1'b1;
        stall_fetch = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        repeat (3) step();
        rst = 1'b0;
        model_redirect(RESET_PC_DEF);
        #1;
        check("first_imem_rd", 32'(bus.imem_rd), 32'd1);
        check("first_imem_addr", 32'(bus.imem_addr), 32'h0000);

        // Done every 2nd cycle; a 3-cycle stall lands on the 0xA5A5 return; HALT at 0x0006.
        for (int c = 1; c < 20; c++) begin
            step();
            stall_fetch = (c >= 5 && c <= 7);
        end
        check("halt_delivery_count", 32'(deliveries), 32'd4);
        check("halted_after_halt", 32'(fetch_halted), 32'd1);
        repeat (10) step();

        // Leave HALTED via redirect.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        model_redirect(16'h0010);
        step();
        redirect_valid = 1'b0;
        check("halted_cleared", 32'(fetch_halted), 32'd0);
        check("redirect_addr", 32'(bus.imem_addr), 32'h0010);
        repeat (10) step();

        // Wrap from 0xFFFE to 0x0000.
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        model_redirect(16'hFFFE);
        step();
        redirect_valid = 1'b0;
        repeat (12) step();

        // Slow memory: redirect while a request is pending, then a younger one during drain.
        lat_fixed = 3;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0041;
        model_redirect(16'h0041);
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        model_redirect(16'h0080);
        step();
        redirect_pc = 16'h0040;
        model_redirect(16'h0040);
        step();
        redirect_valid = 1'b0;
        repeat (20) step();

`ifdef FETCH_ALIGN_CHK_EN
        // Misaligned redirect: error flag, halt after drain, reset clears both.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0011;
        expq.delete();
        model_halted = 1'b0;
        err_halt_ok = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("align_err_set", 32'(fetch_err), 32'd1);
        repeat (8) step();
        check("align_halted", 32'(fetch_halted), 32'd1);
        check("align_err_sticky", 32'(fetch_err), 32'd1);
        rst = 1'b1;
        step();
        check("align_err_cleared", 32'(fetch_err), 32'd0);
        rst = 1'b0;
        model_redirect(RESET_PC_DEF);
        err_halt_ok = 1'b0;
        #1;
        check("align_halt_cleared", 32'(fetch_halted), 32'd0);
`endif

        // Random phase with a mid-run reset.
        lat_fixed = -1;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (i == 2000) begin
                rst = 1'b1;
                redirect_valid = 1'b0;
                expq.delete();
                model_halted = 1'b0;
                continue;
            end
            if (i == 2002) begin
                rst = 1'b0;
                model_redirect(RESET_PC_DEF);
            end
            if (rst) continue;
            stall_fetch = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 11) == 0) begin
                t = 16'($urandom);
`ifdef FETCH_ALIGN_CHK_EN
                t[0] = 1'b0;
`endif
                redirect_valid = 1'b1;
                redirect_pc = t;
                model_redirect(t);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        step();
        redirect_valid = 1'b0;
        stall_fetch = 1'b0;
        repeat (4) step();
        check("progress", 32'(deliveries > 300), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
